// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS pipeline constants and redirect kinds.
package mips_pkg;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
    localparam logic [31:0] IM_BASE    = 32'h0000_3000;
    localparam logic [31:0] IM_LIMIT   = 32'h0000_6FFF;
    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    // Encoding order is the priority order, so kinds compare numerically.
    typedef enum logic [1:0] {NONE, BRANCH, ERET, EXC} redirect_kind_t;
endpackage

// File: rtl/npc_gen.sv
// npc_gen: next-PC selection with a held redirect that survives fetch stalls.
module npc_gen
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        pc_en,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic        exc_req,
    output logic [31:0] next_pc,
    output logic        redirect_pending,
    output logic        pc_fault
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t         state_q, state_d;
    logic [31:0]    held_tgt_q, held_tgt_d;
    redirect_kind_t held_kind_q, held_kind_d;
    redirect_kind_t fresh_kind;
    logic [31:0]    fresh_tgt;
    logic           take_fresh;
    always_comb begin
        fresh_kind = exc_req ? EXC : eret_req ? ERET : (jump || br_taken) ? BRANCH : NONE;
        fresh_tgt  = exc_req ? EXC_VECTOR : eret_req ? epc : jump ? jump_target : br_target;
        take_fresh = (state_q == IDLE) ? (fresh_kind != NONE) : (fresh_kind > held_kind_q);
        state_d     = state_q;
        held_tgt_d  = held_tgt_q;
        held_kind_d = held_kind_q;
        next_pc     = take_fresh ? fresh_tgt : (state_q == HOLD) ? held_tgt_q : pc + 32'd4;
        if (pc_en) begin
            state_d     = IDLE;
            held_kind_d = NONE;
        end else if (take_fresh) begin
            state_d     = HOLD;
            held_tgt_d  = fresh_tgt;
            held_kind_d = fresh_kind;
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            held_tgt_q  <= 32'd0;
            held_kind_q <= NONE;
        end else begin
            state_q     <= state_d;
            held_tgt_q  <= held_tgt_d;
            held_kind_q <= held_kind_d;
        end
    end
    assign redirect_pending = (state_q == HOLD);
    assign pc_fault = (next_pc[1:0] != 2'b00) || (next_pc < IM_BASE) || (next_pc > IM_LIMIT);
endmodule

// File: doc/npc_gen.md
# npc_gen

Next-PC generator for the MIPS pipeline: produces the `next_pc` value consumed by the fetch PC register and decides between sequential fetch, branch/jump targets, exception entry and `eret` return. It holds any redirect that arrives while fetch is stalled, so a stall never loses a redirect. The block sits between the D-stage branch unit / CP0 and the PC register. It shares that register's enable (`pc_en`).

## Interface
- `EXC_VECTOR`, 32'h0000_4180, exception handler entry address
- `IM_BASE`, 32'h0000_3000, lowest legal fetch address
- `IM_LIMIT`, 32'h0000_6FFF, highest legal fetch byte address
- `clk` input 1: single clock, all state on rising edge
- `rst` input 1: reset, asynchronous, active-low (asserted when 0)
- `pc` input 32: current fetch PC from the PC register
- `pc_en` input 1: PC register load enable; 0 = fetch stalled
- `br_taken` input 1: D-stage branch resolved taken
- `br_target` input 32: branch target
- `jump` input 1: D-stage j/jal/jr/jalr
- `jump_target` input 32: jump target
- `eret_req` input 1: CP0 eret commit
- `epc` input 32: CP0 EPC value
- `exc_req` input 1: CP0 exception/interrupt entry
- `next_pc` output 32: value loaded into the PC register when `pc_en`=1
- `redirect_pending` output 1: a stalled redirect is being held
- `pc_fault` output 1: `next_pc` misaligned or outside [IM_BASE, IM_LIMIT]

## Operation
- Fresh-request priority: `exc_req` > `eret_req` > `jump` > `br_taken`. The winning request supplies the target: EXC_VECTOR, `epc`, `jump_target` or `br_target`.
- The FSM has two states, IDLE and HOLD. The held register stores the target (32 bits) and its kind (NONE/BRANCH/ERET/EXC).
- IDLE, no fresh request: `next_pc = pc + 4`, with 32-bit wrap and the carry discarded.
- IDLE, fresh request: `next_pc` = winning target.
  - If `pc_en`=0: capture the target and kind, then go to HOLD.
  - If `pc_en`=1: stay in IDLE.
- HOLD: `next_pc` = held target, unless a fresh request of strictly higher kind is present. In that case `next_pc` = the fresh target, and if `pc_en`=0 the held register is overwritten with it.
- HOLD rules for fresh requests:
  - A fresh request of equal or lower kind is ignored; in particular a fresh branch/jump does not displace a held branch/jump.
  - A fresh `exc_req` always wins, including over a held ERET.
- HOLD with `pc_en`=1: the PC loads `next_pc`, the held kind clears to NONE, and the FSM returns to IDLE.
- `redirect_pending` = (state == HOLD).
- `pc_fault` = (`next_pc[1:0]` != 0) or `next_pc` < IM_BASE or `next_pc` > IM_LIMIT. Unsigned compare; combinational.
- Reset (`rst`=0, any time, including mid-HOLD):
  - state = IDLE, held target = 0, held kind = NONE.
  - `redirect_pending` = 0, and `next_pc` reverts at once to `pc + 4`.
  - Any held redirect is discarded.

## Timing
- `next_pc`, `redirect_pending` and `pc_fault` are combinational from the inputs and the current state. There is zero-cycle latency from a fresh request to `next_pc`.
- State and the held register update only on the `clk` rising edge, or asynchronously on `rst` falling.
- A redirect seen with `pc_en`=0 at edge N appears in the PC at the first edge M>N where `pc_en`=1. Requesters may drop their request after edge N.
- Request inputs are sampled only when they are 1; deassertion while in HOLD has no effect.

## Structure
- Shared package `mips_pkg`:
  - constants EXC_VECTOR, IM_BASE, IM_LIMIT, RESET_PC (32'h0000_3000);
  - enum `redirect_kind_t` {NONE, BRANCH, ERET, EXC}, ordered so that kind priority is a numeric compare. Jumps use BRANCH.
- Single module, no sub-modules. The held target/kind register is small enough to stay inline.

## Test plan
- Reset, `pc`=32'h3000, no requests -> `next_pc`=32'h3004, `redirect_pending`=0, `pc_fault`=0.
- `br_taken`=1, `br_target`=32'h3040, `pc_en`=0 for 3 cycles, requests dropped after the first -> `next_pc`=32'h3040 throughout, `redirect_pending`=1. The cycle after `pc_en`=1, `redirect_pending`=0 and `next_pc`=`pc`+4.
- HOLD BRANCH 32'h3040, then `exc_req` with `pc_en`=0 -> `next_pc`=32'h4180. The held kind becomes EXC; a later `eret_req` (`epc`=32'h3100) is ignored until released.
- Same cycle `jump` (32'h3200) and `br_taken` (32'h3300), `pc_en`=1 -> `next_pc`=32'h3200, state stays IDLE.
- `jump_target`=32'h3002 -> `pc_fault`=1. `jump_target`=32'h7000 -> `pc_fault`=1. `pc`=32'hFFFF_FFFC with no request -> `next_pc`=0, `pc_fault`=1.
- In HOLD (ERET, `epc`=32'h3100), assert `rst`=0 mid-cycle -> `redirect_pending`=0 and `next_pc`=`pc`+4 immediately, before the next clock edge.
